shift_reg_bank: RTL and testbench

Parametrised successor to the single-bit negative-edge D flip-flop: a WIDTH-bit register with selectable capture edge, asynchronous reset, clock enable and eight operations (hold, parallel load, logical shifts, rotates, arithmetic shift right, clear). It also provides a serial-out bit and a bits-remaining counter, so it can serve as a parallel-to-serial converter in datapath and serial-link blocks.

---
 rtl/shift_reg_bank.sv | 120 ++++++++++++
 tb/tb_shift_reg_bank.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_bank.sv
// WIDTH-bit shift/rotate register with selectable capture edge, serial-out bit
// and a saturating count of loaded bits still waiting to be shifted out.
module shift_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter bit               NEG_EDGE  = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [2:0]                 op,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin,
  output logic [WIDTH-1:0]           q,
  output logic                       sout,
  output logic [$clog2(WIDTH+1)-1:0] bits_left,
  output logic                       drained
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_SHL   = 3'd2,
    OP_SHR   = 3'd3,
    OP_ROTL  = 3'd4,
    OP_ROTR  = 3'd5,
    OP_ASR   = 3'd6,
    OP_CLEAR = 3'd7
  } op_e;

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CW-1:0]    w_cnt_dec;

  // Counter saturates at zero; shifting itself keeps going on a drained register.
  assign w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - CW'(1);

  always_comb begin
    w_q_nxt    = r_q;
    w_sout_nxt = r_sout;
    w_cnt_nxt  = r_cnt;
    case (op_e'(op))
      OP_HOLD: ;
      OP_LOAD: begin
        w_q_nxt   = d;
        w_cnt_nxt = CW'(WIDTH);
      end
      OP_SHL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], sin};
        w_sout_nxt = r_q[WIDTH-1];
        w_cnt_nxt  = w_cnt_dec;
      end
      OP_SHR: begin
        w_q_nxt    = {sin, r_q[WIDTH-1:1]};
        w_sout_nxt = r_q[0];
        w_cnt_nxt  = w_cnt_dec;
      end
      OP_ROTL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_sout_nxt = r_q[WIDTH-1];
      end
      OP_ROTR: begin
        w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
        w_sout_nxt = r_q[0];
      end
      OP_ASR: begin
        w_q_nxt    = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
        w_sout_nxt = r_q[0];
        w_cnt_nxt  = w_cnt_dec;
      end
      OP_CLEAR: begin
        w_q_nxt   = '0;
        w_cnt_nxt = '0;
      end
      default: ;
    endcase
  end

  // Only the sensitivity edge differs between the two builds.
  generate
    if (NEG_EDGE) begin : g_neg
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          r_q    <= RESET_VAL;
          r_sout <= 1'b0;
          r_cnt  <= '0;
        end else if (en) begin
          r_q    <= w_q_nxt;
          r_sout <= w_sout_nxt;
          r_cnt  <= w_cnt_nxt;
        end
      end
    end else begin : g_pos
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_q    <= RESET_VAL;
          r_sout <= 1'b0;
          r_cnt  <= '0;
        end else if (en) begin
          r_q    <= w_q_nxt;
          r_sout <= w_sout_nxt;
          r_cnt  <= w_cnt_nxt;
        end
      end
    end
  endgenerate

  assign q         = r_q;
  assign sout      = r_sout;
  assign bits_left = r_cnt;
  assign drained   = (r_cnt == '0);

endmodule

// File: tb/tb_shift_reg_bank.sv
// Directed bench: an 8-bit falling-edge instance and a 4-bit rising-edge
// instance sharing one clock, checked against hand-computed values.
module tb_shift_reg_bank;

  int total = 0;
  int bad   = 0;

  logic       clk = 1'b0;
  logic       rst;

  logic       en8, sin8;
  logic [2:0] op8;
  logic [7:0] d8, q8;
  logic       sout8, drained8;
  logic [3:0] bl8;

  logic       en4, sin4;
  logic [2:0] op4;
  logic [3:0] d4, q4;
  logic       sout4, drained4;
  logic [2:0] bl4;

  always #5 clk = ~clk;

  shift_reg_bank #(.WIDTH(8), .NEG_EDGE(1'b1), .RESET_VAL(8'h3C)) dut8 (
    .clk(clk), .rst(rst), .en(en8), .op(op8), .d(d8), .sin(sin8),
    .q(q8), .sout(sout8), .bits_left(bl8), .drained(drained8)
  );

  shift_reg_bank #(.WIDTH(4), .NEG_EDGE(1'b0), .RESET_VAL(4'h0)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .op(op4), .d(d4), .sin(sin4),
    .q(q4), .sout(sout4), .bits_left(bl4), .drained(drained4)
  );

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // Apply one operation to the 8-bit instance; returns 1 ns after its falling edge.
  task automatic step8(input logic [2:0] op, input logic [7:0] d, input logic sin);
    en8  = 1'b1;
    op8  = op;
    d8   = d;
    sin8 = sin;
    @(negedge clk);
    #1;
    op8 = 3'd0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en8 = 1'b0; op8 = 3'd0; d8 = 8'h00; sin8 = 1'b0;
    en4 = 1'b0; op4 = 3'd0; d4 = 4'h0; sin4 = 1'b0;
    #2;
    total++; if (q8 !== 8'h3C) begin bad++; $display("FAIL reset_q8 got=%h exp=3c", q8); end
    total++; if (sout8 !== 1'b0) begin bad++; $display("FAIL reset_sout8 got=%b exp=0", sout8); end
    total++; if (bl8 !== 4'd0) begin bad++; $display("FAIL reset_bits8 got=%0d exp=0", bl8); end
    total++; if (drained8 !== 1'b1) begin bad++; $display("FAIL reset_drained8 got=%b exp=1", drained8); end
    total++; if (q4 !== 4'h0) begin bad++; $display("FAIL reset_q4 got=%h exp=0", q4); end
    @(negedge clk);
    @(negedge clk);
    #1;
    total++; if (q8 !== 8'h3C) begin bad++; $display("FAIL reset_held_q8 got=%h exp=3c", q8); end
    rst = 1'b0;
  endtask

  task automatic test_async_reset;
    step8(3'd1, 8'hFF, 1'b0);
    step8(3'd2, 8'h00, 1'b0);
    step8(3'd2, 8'h00, 1'b0);
    total++; if (q8 !== 8'hFC) begin bad++; $display("FAIL ar_pre_q got=%h exp=fc", q8); end
    total++; if (bl8 !== 4'd6) begin bad++; $display("FAIL ar_pre_bits got=%0d exp=6", bl8); end
    total++; if (sout8 !== 1'b1) begin bad++; $display("FAIL ar_pre_sout got=%b exp=1", sout8); end
    #2;
    rst = 1'b1;
    #1;
    total++; if (q8 !== 8'h3C) begin bad++; $display("FAIL ar_q got=%h exp=3c", q8); end
    total++; if (sout8 !== 1'b0) begin bad++; $display("FAIL ar_sout got=%b exp=0", sout8); end
    total++; if (bl8 !== 4'd0) begin bad++; $display("FAIL ar_bits got=%0d exp=0", bl8); end
    total++; if (drained8 !== 1'b1) begin bad++; $display("FAIL ar_drained got=%b exp=1", drained8); end
    #1;
    rst = 1'b0;
    step8(3'd1, 8'h11, 1'b0);
    total++; if (q8 !== 8'h11) begin bad++; $display("FAIL ar_first_load got=%h exp=11", q8); end
  endtask

  task automatic test_drain;
    logic [7:0] exp_sout;
    logic [7:0] exp_q;
    exp_sout = 8'b1010_0101;
    exp_q    = 8'hA5;
    step8(3'd1, 8'hA5, 1'b0);
    total++; if (bl8 !== 4'd8) begin bad++; $display("FAIL drain_load_bits got=%0d exp=8", bl8); end
    total++; if (drained8 !== 1'b0) begin bad++; $display("FAIL drain_load_drained got=%b exp=0", drained8); end
    for (int i = 0; i < 8; i++) begin
      step8(3'd2, 8'h00, 1'b0);
      exp_q = exp_q << 1;
      total++; if (sout8 !== exp_sout[7-i]) begin bad++; $display("FAIL drain_sout[%0d] got=%b exp=%b", i, sout8, exp_sout[7-i]); end
      total++; if (bl8 !== 4'(7 - i)) begin bad++; $display("FAIL drain_bits[%0d] got=%0d exp=%0d", i, bl8, 7 - i); end
      total++; if (q8 !== exp_q) begin bad++; $display("FAIL drain_q[%0d] got=%h exp=%h", i, q8, exp_q); end
      total++; if (drained8 !== (i == 7)) begin bad++; $display("FAIL drain_drained[%0d] got=%b exp=%b", i, drained8, (i == 7)); end
    end
    step8(3'd2, 8'h00, 1'b0);
    total++; if (bl8 !== 4'd0) begin bad++; $display("FAIL drain_sat_bits got=%0d exp=0", bl8); end
    total++; if (q8 !== 8'h00) begin bad++; $display("FAIL drain_sat_q got=%h exp=00", q8); end
    total++; if (drained8 !== 1'b1) begin bad++; $display("FAIL drain_sat_drained got=%b exp=1", drained8); end
    step8(3'd1, 8'h0F, 1'b0);
    step8(3'd2, 8'h00, 1'b1);
    total++; if (q8 !== 8'h1F) begin bad++; $display("FAIL shl_sin_q got=%h exp=1f", q8); end
    step8(3'd3, 8'h00, 1'b1);
    total++; if (q8 !== 8'h8F) begin bad++; $display("FAIL shr_sin_q got=%h exp=8f", q8); end
    total++; if (sout8 !== 1'b1) begin bad++; $display("FAIL shr_sin_sout got=%b exp=1", sout8); end
    total++; if (bl8 !== 4'd6) begin bad++; $display("FAIL shr_sin_bits got=%0d exp=6", bl8); end
  endtask

  task automatic test_rot_asr;
    step8(3'd1, 8'h81, 1'b0);
    step8(3'd5, 8'h00, 1'b0);
    total++; if (q8 !== 8'hC0) begin bad++; $display("FAIL rotr_q got=%h exp=c0", q8); end
    total++; if (sout8 !== 1'b1) begin bad++; $display("FAIL rotr_sout got=%b exp=1", sout8); end
    total++; if (bl8 !== 4'd8) begin bad++; $display("FAIL rotr_bits got=%0d exp=8", bl8); end
    step8(3'd4, 8'h00, 1'b0);
    step8(3'd4, 8'h00, 1'b0);
    total++; if (q8 !== 8'h03) begin bad++; $display("FAIL rotl_q got=%h exp=03", q8); end
    total++; if (sout8 !== 1'b1) begin bad++; $display("FAIL rotl_sout got=%b exp=1", sout8); end
    total++; if (bl8 !== 4'd8) begin bad++; $display("FAIL rotl_bits got=%0d exp=8", bl8); end
    step8(3'd1, 8'h80, 1'b0);
    for (int i = 0; i < 3; i++) step8(3'd6, 8'h00, 1'b1);
    total++; if (q8 !== 8'hF0) begin bad++; $display("FAIL asr_q got=%h exp=f0", q8); end
    total++; if (sout8 !== 1'b0) begin bad++; $display("FAIL asr_sout got=%b exp=0", sout8); end
    total++; if (bl8 !== 4'd5) begin bad++; $display("FAIL asr_bits got=%0d exp=5", bl8); end
    step8(3'd0, 8'hAA, 1'b1);
    total++; if (q8 !== 8'hF0 || bl8 !== 4'd5) begin bad++; $display("FAIL hold got q=%h bits=%0d exp q=f0 bits=5", q8, bl8); end
  endtask

  task automatic test_enable_edge;
    en8 = 1'b0; op8 = 3'd1; d8 = 8'h55;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      total++; if (q8 !== 8'hF0 || bl8 !== 4'd5) begin bad++; $display("FAIL en0_hold[%0d] got q=%h bits=%0d exp q=f0 bits=5", i, q8, bl8); end
    end
    en8 = 1'b1;
    @(posedge clk);
    #1;
    total++; if (q8 !== 8'hF0) begin bad++; $display("FAIL rise_no_capture got=%h exp=f0", q8); end
    @(negedge clk);
    #1;
    total++; if (q8 !== 8'h55) begin bad++; $display("FAIL fall_capture got=%h exp=55", q8); end
    total++; if (bl8 !== 4'd8) begin bad++; $display("FAIL fall_capture_bits got=%0d exp=8", bl8); end
    op8 = 3'd0;
  endtask

  task automatic test_clear;
    step8(3'd1, 8'h81, 1'b0);
    step8(3'd2, 8'h00, 1'b0);
    total++; if (q8 !== 8'h02 || sout8 !== 1'b1) begin bad++; $display("FAIL clr_pre got q=%h sout=%b exp q=02 sout=1", q8, sout8); end
    step8(3'd1, 8'h7E, 1'b0);
    total++; if (sout8 !== 1'b1) begin bad++; $display("FAIL load_keeps_sout got=%b exp=1", sout8); end
    step8(3'd7, 8'h00, 1'b0);
    total++; if (q8 !== 8'h00) begin bad++; $display("FAIL clear_q got=%h exp=00", q8); end
    total++; if (bl8 !== 4'd0) begin bad++; $display("FAIL clear_bits got=%0d exp=0", bl8); end
    total++; if (drained8 !== 1'b1) begin bad++; $display("FAIL clear_drained got=%b exp=1", drained8); end
    total++; if (sout8 !== 1'b1) begin bad++; $display("FAIL clear_sout got=%b exp=1", sout8); end
  endtask

  task automatic test_rising;
    en4 = 1'b1; op4 = 3'd1; d4 = 4'b1001; sin4 = 1'b0;
    @(posedge clk);
    #1;
    total++; if (q4 !== 4'b1001) begin bad++; $display("FAIL r4_load got=%b exp=1001", q4); end
    total++; if (bl4 !== 3'd4) begin bad++; $display("FAIL r4_load_bits got=%0d exp=4", bl4); end
    op4 = 3'd3; sin4 = 1'b1;
    @(posedge clk);
    #1;
    total++; if (q4 !== 4'b1100) begin bad++; $display("FAIL r4_shr_q got=%b exp=1100", q4); end
    total++; if (sout4 !== 1'b1) begin bad++; $display("FAIL r4_shr_sout got=%b exp=1", sout4); end
    total++; if (bl4 !== 3'd3) begin bad++; $display("FAIL r4_shr_bits got=%0d exp=3", bl4); end
    op4 = 3'd7;
    @(negedge clk);
    #1;
    total++; if (q4 !== 4'b1100) begin bad++; $display("FAIL r4_fall_ignored got=%b exp=1100", q4); end
    en4 = 1'b0;
    @(posedge clk);
    #1;
    total++; if (q4 !== 4'b1100) begin bad++; $display("FAIL r4_en0 got=%b exp=1100", q4); end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_drain();
    test_rot_asr();
    test_enable_edge();
    test_clear();
    test_rising();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
